// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder, one WIDTH/STAGES-bit slice per stage
// Valid/ready on both sides with a single global stall; results leave in order.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICE = WIDTH / STAGES;

  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic             src_v [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [SLICE:0]   slice_sum [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];

  logic advance;

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;

  always_comb begin
    src_v[0] = in_valid;
    src_c[0] = cin;
    src_a[0] = a;
    src_b[0] = b;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_c[k] = c_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
    end
    // Each stage adds its own slice and splices it into the partial sum.
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, src_a[k][k*SLICE +: SLICE]}
                   + {1'b0, src_b[k][k*SLICE +: SLICE]}
                   + (SLICE+1)'(src_c[k]);
      s_d[k] = src_s[k];
      s_d[k][k*SLICE +: SLICE] = slice_sum[k][SLICE-1:0];
      c_d[k] = slice_sum[k][SLICE];
    end
  end

  // Data only loads behind a valid bit, so bubbles leave sum/cout untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          c_q[k] <= c_d[k];
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= s_d[k];
        end
      end
    end
  end

endmodule
